// File: rtl/result_serializer.sv
// result_serializer: FIFO-buffered MSB-first serializer of 2*N-bit result words
// Ports: clk/reset (async, active-high); in_data/in_valid/in_ready push side;
// ser_bit/ser_valid/ser_last/ser_ready serial side; full/empty FIFO status.
module result_serializer #(
  parameter int N = 24,
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [2*N-1:0] in_data,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           ser_ready,
  output logic           ser_valid,
  output logic           ser_bit,
  output logic           ser_last,
  output logic           full,
  output logic           empty
);
  localparam int W = 2 * N;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state_q, state_d;
  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] sr_q, sr_d;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] fifo_cnt_q, fifo_cnt_d;
  logic push, pop, load_slot;
  assign full = fifo_cnt_q == (AW+1)'(DEPTH);
  assign empty = fifo_cnt_q == '0;
  assign in_ready = !full;
  assign push = in_valid && in_ready;
  assign ser_valid = state_q == SHIFT;
  assign ser_bit = ser_valid && sr_q[W-1];
  assign ser_last = ser_valid && bit_cnt_q == '0;
  // A new word may be loaded from IDLE, or right as the last bit is taken so
  // consecutive words stream without a gap.
  assign load_slot = state_q == IDLE || (ser_ready && bit_cnt_q == '0);
  always_comb begin
    state_d = state_q;
    sr_d = sr_q;
    bit_cnt_d = bit_cnt_q;
    pop = 1'b0;
    if (load_slot) begin
      pop = !empty;
      state_d = empty ? IDLE : SHIFT;
      sr_d = empty ? sr_q : mem[rd_q];
      bit_cnt_d = empty ? bit_cnt_q : LAST;
    end else if (ser_ready) begin
      sr_d = {sr_q[W-2:0], 1'b0};
      bit_cnt_d = bit_cnt_q - CW'(1);
    end
    wr_d = wr_q + AW'(push);
    rd_d = rd_q + AW'(pop);
    fifo_cnt_d = fifo_cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sr_q <= '0;
      bit_cnt_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      fifo_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      sr_q <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      fifo_cnt_q <= fifo_cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_q] <= in_data;
  end
endmodule
